// File: rtl/timer_prescaler_if.sv
// Control, event-pin and tick bundle between timer_prescaler and its neighbours.
// master drives configuration and the external pin; slave is the prescaler.
interface timer_prescaler_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             en;
  logic             gate;
  logic             cfg_load;
  logic             src_sel;
  logic [1:0]       edge_sel;
  logic [3:0]       div_sel;
  logic             ext_in;
  logic             tick;
  logic             ext_edge;
  logic [CNT_W-1:0] prescale_cnt;

  modport master (
    output en, gate, cfg_load, src_sel, edge_sel, div_sel, ext_in,
    input  tick, ext_edge, prescale_cnt
  );

  modport slave (
    input  en, gate, cfg_load, src_sel, edge_sel, div_sel, ext_in,
    output tick, ext_edge, prescale_cnt
  );
endinterface

// File: rtl/timer_prescaler.sv
// Event source select, external-pin synchronizer/edge detector and 2^div prescaler feeding the counter core.
// Optional macro PRESCALER_GLITCH_FILTER_EN inserts a 3-clock stability filter after the synchronizer.
module timer_prescaler #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  timer_prescaler_if.slave bus
);

  localparam int unsigned DIV_W = 4;
`ifdef PRESCALER_GLITCH_FILTER_EN
  localparam int unsigned ARM_CYC = SYNC_STAGES + 3;
`else
  localparam int unsigned ARM_CYC = SYNC_STAGES + 1;
`endif
  localparam int unsigned ARM_W = $clog2(ARM_CYC + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_armed;
  logic [ARM_W-1:0]       r_arm_cnt;
  logic                   r_ext_edge;
  logic                   r_src;
  logic [1:0]             r_edge;
  logic [DIV_W-1:0]       r_div;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_tick;

  logic                   w_sync_lvl;
  logic                   w_lvl;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_qual;
  logic                   w_ext_evt;
  logic                   w_event;
  logic [DIV_W-1:0]       w_div_c;
  logic [CNT_W-1:0]       w_mask;
  logic                   w_term;

  assign w_sync_lvl = r_sync[SYNC_STAGES-1];

`ifdef PRESCALER_GLITCH_FILTER_EN
  logic [1:0] r_hist;
  logic       r_filt;

  // Level passes only once the last three synchronized samples agree.
  assign w_lvl = ((w_sync_lvl == r_hist[0]) && (r_hist[0] == r_hist[1])) ? w_sync_lvl : r_filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= 2'b00;
      r_filt <= 1'b0;
    end else begin
      r_hist <= {r_hist[0], w_sync_lvl};
      r_filt <= w_lvl;
    end
  end
`else
  assign w_lvl = w_sync_lvl;
`endif

  assign w_rise = w_lvl & ~r_prev;
  assign w_fall = ~w_lvl & r_prev;

  always_comb begin
    w_qual = 1'b0;
    case (r_edge)
      2'b00:   w_qual = w_rise;
      2'b01:   w_qual = w_fall;
      2'b10:   w_qual = w_rise | w_fall;
      default: w_qual = 1'b0;
    endcase
  end

  assign w_ext_evt = w_qual & r_armed;
  assign w_event   = r_src ? w_ext_evt : 1'b1;

  always_comb begin
    w_div_c = r_div;
    if (32'(r_div) > CNT_W - 1) w_div_c = DIV_W'(CNT_W - 1);
  end

  assign w_mask = ~({CNT_W{1'b1}} << w_div_c);
  assign w_term = (r_cnt == w_mask);

  // Synchronizer, edge history and arming; untouched by en/gate/cfg_load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync     <= '0;
      r_prev     <= 1'b0;
      r_armed    <= 1'b0;
      r_arm_cnt  <= '0;
      r_ext_edge <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], bus.ext_in};
      r_prev     <= w_lvl;
      r_ext_edge <= w_ext_evt;
      if (!r_armed) begin
        if (r_arm_cnt == ARM_W'(ARM_CYC - 1)) r_armed <= 1'b1;
        else                                   r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      end
    end
  end

  // Shadow config and prescale counter; cfg_load beats a same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src  <= 1'b0;
      r_edge <= 2'b00;
      r_div  <= '0;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (bus.cfg_load) begin
      r_src  <= bus.src_sel;
      r_edge <= bus.edge_sel;
      r_div  <= bus.div_sel;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!bus.en) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (bus.gate && w_event) begin
      if (w_term) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign bus.tick         = r_tick;
  assign bus.ext_edge     = r_ext_edge;
  assign bus.prescale_cnt = r_cnt;

endmodule
